// File: rtl/data_mem_responder_pkg.sv
// Shared MEM-stage definitions: responder FSM encoding, data word width and
// the word-alignment mask also used by the MEM stage address logic.
package data_mem_responder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int WORD_W = 32;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_word_array.sv
// Single-port DEPTH x WORD_W synchronous RAM with a registered read port.
// Array contents are never reset; only the read-data register is.
module mem_word_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read data only moves on a completed read, so it holds across writes and errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: validates MEM-stage requests, stalls the pipeline
// for LATENCY cycles, then commits the write or returns registered read data.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_En,
    input  logic              write_En,
    input  logic [WORD_W-1:0] DataAddress,
    input  logic [WORD_W-1:0] WriteData,
    output logic [WORD_W-1:0] ReadData,
    output logic              rvalid,
    output logic              stall,
    output logic              mem_err
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              op_write;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;

    logic              req_one;
    logic              req_any;
    logic              aligned;
    logic              in_range;
    logic              valid_req;
    logic              bad_req;
    logic              finish;
    logic              acc_write;
    logic [AW-1:0]     acc_idx;
    logic [WORD_W-1:0] acc_wdata;

    assign req_one   = read_En ^ write_En;
    assign req_any   = read_En | write_En;
    assign aligned   = (DataAddress[1:0] & ALIGN_MASK) == 2'b00;
    assign in_range  = (DataAddress[WORD_W-1:AW+2] == '0);
    assign valid_req = req_one && aligned && in_range;
    assign bad_req   = req_any && !valid_req;

    // The access fires on the edge entering DONE; with LATENCY==1 that edge
    // closes the accepting IDLE cycle, so the live inputs are used directly.
    assign finish    = reset && (((state == IDLE) && valid_req && (LATENCY == 1)) ||
                                 ((state == WAIT) && (cnt == 4'd0)));
    assign acc_write = (state == IDLE) ? write_En : op_write;
    assign acc_idx   = (state == IDLE) ? DataAddress[AW+1:2] : idx_q;
    assign acc_wdata = (state == IDLE) ? WriteData : wdata_q;

    assign stall = reset && (((state == IDLE) && valid_req) || (state == WAIT));

    mem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (finish && acc_write),
        .re    (finish && !acc_write),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (ReadData)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rvalid   <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            rvalid  <= finish && !acc_write;
            mem_err <= (state == IDLE) && bad_req;
            case (state)
                IDLE: begin
                    if (valid_req) begin
                        op_write <= write_En;
                        idx_q    <= DataAddress[AW+1:2];
                        wdata_q  <= WriteData;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
